// File: rtl/sys_move_pkg.sv
// Shared decode types for the system/move execution unit.
package sys_move_pkg;

    typedef enum logic [2:0] {
        SYS_NOP           = 3'd0,
        SYS_MOVE_TO_SPR   = 3'd1,
        SYS_MOVE_FROM_SPR = 3'd2,
        SYS_MOVE_TO_CR    = 3'd3,
        SYS_MOVE_FROM_CR  = 3'd4,
        SYS_SYNC          = 3'd5,
        SYS_TRAP          = 3'd6,
        SYS_RESERVED      = 3'd7
    } system_op_t;

    typedef struct packed {
        system_op_t  operation;
        logic [0:9]  SPR;
        logic [0:7]  FXM;
    } system_decode_t;

endpackage

// File: rtl/sys_move_unit.sv
// System/move execution unit: PIPE_DEPTH-slot elastic pipe routing results to GPR, SPR or CR writeback.
// Optional feature macro SYS_MOVE_MFOCRF_EN: mfcr results keep only the CR fields selected by FXM.
module sys_move_unit
    import sys_move_pkg::*;
#(
    parameter int RS_ID_WIDTH = 5,
    parameter int PIPE_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [RS_ID_WIDTH-1:0] rs_id_in,
    input  logic [4:0]             result_reg_addr_in,
    input  logic [31:0]            op1,
    input  system_decode_t         control,
    output logic                   gpr_output_valid,
    input  logic                   gpr_output_ready,
    output logic [RS_ID_WIDTH-1:0] gpr_rs_id_out,
    output logic [4:0]             gpr_result_reg_addr_out,
    output logic [31:0]            gpr_result,
    output logic                   spr_output_valid,
    input  logic                   spr_output_ready,
    output logic [RS_ID_WIDTH-1:0] spr_rs_id_out,
    output logic [9:0]             spr_result_reg_addr_out,
    output logic [31:0]            spr_result,
    output logic                   cr_output_valid,
    input  logic                   cr_output_ready,
    output logic [RS_ID_WIDTH-1:0] cr_rs_id_out,
    output logic                   cr_enable [0:7],
    output logic [31:0]            cr_result
);

    localparam int LAST = PIPE_DEPTH - 1;

    logic [PIPE_DEPTH-1:0]  vld_p;
    logic [RS_ID_WIDTH-1:0] id_p   [PIPE_DEPTH];
    logic [4:0]             addr_p [PIPE_DEPTH];
    system_decode_t         ctrl_p [PIPE_DEPTH];
    logic [31:0]            op1_p  [PIPE_DEPTH];

    logic [PIPE_DEPTH-1:0]  src_vld;
    logic [RS_ID_WIDTH-1:0] src_id   [PIPE_DEPTH];
    logic [4:0]             src_addr [PIPE_DEPTH];
    system_decode_t         src_ctrl [PIPE_DEPTH];
    logic [31:0]            src_op1  [PIPE_DEPTH];

    logic [PIPE_DEPTH-1:0]  load;
    logic                   to_gpr;
    logic                   to_spr;
    logic                   to_cr;
    logic                   drain;

`ifdef SYS_MOVE_MFOCRF_EN
    function automatic logic [31:0] mfocrf_mask(input logic [31:0] v, input logic [0:7] fxm);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            if (fxm[k]) r[31-4*k -: 4] = v[31-4*k -: 4];
        end
        return r;
    endfunction
`endif

    // Head decode: an op that maps to no bus is illegal and drains unconditionally.
    always_comb begin
        to_gpr = 1'b0;
        to_spr = 1'b0;
        to_cr  = 1'b0;
        case (ctrl_p[LAST].operation)
            SYS_MOVE_TO_SPR:                     to_spr = 1'b1;
            SYS_MOVE_FROM_SPR, SYS_MOVE_FROM_CR: to_gpr = 1'b1;
            SYS_MOVE_TO_CR:                      to_cr  = 1'b1;
            default: ;
        endcase
        drain = vld_p[LAST] & ((to_gpr & gpr_output_ready) |
                               (to_spr & spr_output_ready) |
                               (to_cr  & cr_output_ready)  |
                               ~(to_gpr | to_spr | to_cr));
    end

    // A slot may load when it or any slot downstream is empty, or the head drains.
    for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_slot
        if (g == 0) begin : g_head
            assign src_vld[g]  = input_valid;
            assign src_id[g]   = rs_id_in;
            assign src_addr[g] = result_reg_addr_in;
            assign src_ctrl[g] = control;
            assign src_op1[g]  = op1;
        end else begin : g_chain
            assign src_vld[g]  = vld_p[g-1];
            assign src_id[g]   = id_p[g-1];
            assign src_addr[g] = addr_p[g-1];
            assign src_ctrl[g] = ctrl_p[g-1];
            assign src_op1[g]  = op1_p[g-1];
        end
        assign load[g] = drain | ~(&vld_p[LAST:g]);
    end

    assign input_ready = load[0];

    // ---- pipeline slot registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                id_p[i]   <= '0;
                addr_p[i] <= '0;
                ctrl_p[i] <= '{operation: SYS_NOP, SPR: '0, FXM: '0};
                op1_p[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                if (load[i]) begin
                    vld_p[i]  <= src_vld[i];
                    id_p[i]   <= src_id[i];
                    addr_p[i] <= src_addr[i];
                    ctrl_p[i] <= src_ctrl[i];
                    op1_p[i]  <= src_op1[i];
                end
            end
        end
    end

    // ---- output slot to writeback buses ----
    always_comb begin
        gpr_output_valid        = vld_p[LAST] & to_gpr;
        spr_output_valid        = vld_p[LAST] & to_spr;
        cr_output_valid         = vld_p[LAST] & to_cr;
        gpr_rs_id_out           = id_p[LAST];
        spr_rs_id_out           = id_p[LAST];
        cr_rs_id_out            = id_p[LAST];
        gpr_result_reg_addr_out = addr_p[LAST];
        spr_result_reg_addr_out = ctrl_p[LAST].SPR;
`ifdef SYS_MOVE_MFOCRF_EN
        gpr_result = (ctrl_p[LAST].operation == SYS_MOVE_FROM_CR) ?
                     mfocrf_mask(op1_p[LAST], ctrl_p[LAST].FXM) : op1_p[LAST];
`else
        gpr_result = op1_p[LAST];
`endif
        spr_result = op1_p[LAST];
        cr_result  = op1_p[LAST];
        for (int k = 0; k < 8; k++) cr_enable[k] = ctrl_p[LAST].FXM[k];
    end

endmodule

// File: tb/tb_sys_move_unit.sv
// Self-checking bench for sys_move_unit: directed scenarios at PIPE_DEPTH=2, randomised scoreboard run at PIPE_DEPTH=4.
module tb_sys_move_unit;
    import sys_move_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // depth-2 instance signals
    logic a_iv, a_ir, a_gv, a_gr, a_sv, a_sr, a_cv, a_cr;
    logic [4:0] a_id, a_ra, a_gid, a_gaddr, a_sid, a_cid;
    logic [31:0] a_op1, a_gres, a_sres, a_cres;
    logic [9:0] a_saddr;
    logic a_cen [0:7];
    system_decode_t a_ctl;

    // depth-4 instance signals
    logic b_iv, b_ir, b_gv, b_gr, b_sv, b_sr, b_cv, b_cr;
    logic [4:0] b_id, b_ra, b_gid, b_gaddr, b_sid, b_cid;
    logic [31:0] b_op1, b_gres, b_sres, b_cres;
    logic [9:0] b_saddr;
    logic b_cen [0:7];
    system_decode_t b_ctl;

    sys_move_unit #(.RS_ID_WIDTH(5), .PIPE_DEPTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .input_valid(a_iv), .input_ready(a_ir),
        .rs_id_in(a_id), .result_reg_addr_in(a_ra), .op1(a_op1), .control(a_ctl),
        .gpr_output_valid(a_gv), .gpr_output_ready(a_gr), .gpr_rs_id_out(a_gid),
        .gpr_result_reg_addr_out(a_gaddr), .gpr_result(a_gres),
        .spr_output_valid(a_sv), .spr_output_ready(a_sr), .spr_rs_id_out(a_sid),
        .spr_result_reg_addr_out(a_saddr), .spr_result(a_sres),
        .cr_output_valid(a_cv), .cr_output_ready(a_cr), .cr_rs_id_out(a_cid),
        .cr_enable(a_cen), .cr_result(a_cres)
    );

    sys_move_unit #(.RS_ID_WIDTH(5), .PIPE_DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .input_valid(b_iv), .input_ready(b_ir),
        .rs_id_in(b_id), .result_reg_addr_in(b_ra), .op1(b_op1), .control(b_ctl),
        .gpr_output_valid(b_gv), .gpr_output_ready(b_gr), .gpr_rs_id_out(b_gid),
        .gpr_result_reg_addr_out(b_gaddr), .gpr_result(b_gres),
        .spr_output_valid(b_sv), .spr_output_ready(b_sr), .spr_rs_id_out(b_sid),
        .spr_result_reg_addr_out(b_saddr), .spr_result(b_sres),
        .cr_output_valid(b_cv), .cr_output_ready(b_cr), .cr_rs_id_out(b_cid),
        .cr_enable(b_cen), .cr_result(b_cres)
    );

    typedef struct {
        int          bus;   // 0 gpr, 1 spr, 2 cr, 3 dropped
        logic [4:0]  id;
        logic [9:0]  addr;
        logic [31:0] res;
        logic [7:0]  fxm;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t model(system_op_t op, logic [4:0] id, logic [4:0] ra,
                                   logic [9:0] spr, logic [7:0] fxm, logic [31:0] d);
        exp_t e;
        e.id   = id;
        e.fxm  = fxm;
        e.res  = d;
        e.addr = {5'd0, ra};
        case (op)
            SYS_MOVE_TO_SPR:   begin e.bus = 1; e.addr = spr; end
            SYS_MOVE_FROM_SPR: e.bus = 0;
            SYS_MOVE_TO_CR:    begin e.bus = 2; e.addr = '0; end
            SYS_MOVE_FROM_CR: begin
                e.bus = 0;
`ifdef SYS_MOVE_MFOCRF_EN
                for (int k = 0; k < 8; k++) if (!fxm[7-k]) e.res[31-4*k -: 4] = 4'h0;
`endif
            end
            default: e.bus = 3;
        endcase
        return e;
    endfunction

    function automatic logic [7:0] pack_en(input logic e [0:7]);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[7-k] = e[k];
        return r;
    endfunction

    task automatic a_set(bit v, system_op_t op, logic [4:0] id, logic [4:0] ra,
                         logic [9:0] spr, logic [7:0] fxm, logic [31:0] d);
        a_iv = v; a_id = id; a_ra = ra; a_op1 = d;
        a_ctl = '{operation: op, SPR: spr, FXM: fxm};
    endtask

    task automatic b_set(bit v, system_op_t op, logic [4:0] id, logic [4:0] ra,
                         logic [9:0] spr, logic [7:0] fxm, logic [31:0] d);
        b_iv = v; b_id = id; b_ra = ra; b_op1 = d;
        b_ctl = '{operation: op, SPR: spr, FXM: fxm};
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (a_ir !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", a_ir); end
        n_cmp++;
        if ({a_gv, a_sv, a_cv} !== 3'b000) begin n_fail++; $display("FAIL reset_valids: got %b want 000", {a_gv, a_sv, a_cv}); end
        n_cmp++;
        if ({a_gid, a_gaddr, a_sid, a_saddr, a_cid} !== 30'd0) begin
            n_fail++; $display("FAIL reset_ids: got %h want 0", {a_gid, a_gaddr, a_sid, a_saddr, a_cid});
        end
        n_cmp++;
        if ({a_gres, a_sres, a_cres} !== 96'd0) begin n_fail++; $display("FAIL reset_results: got %h want 0", {a_gres, a_sres, a_cres}); end
        n_cmp++;
        if (pack_en(a_cen) !== 8'h00) begin n_fail++; $display("FAIL reset_cr_enable: got %h want 00", pack_en(a_cen)); end
        n_cmp++;
        if ({b_ir, b_gv, b_sv, b_cv} !== 4'b1000) begin n_fail++; $display("FAIL reset_d4: got %b want 1000", {b_ir, b_gv, b_sv, b_cv}); end
    endtask

    task automatic test_mtspr;
        @(negedge clk);
        a_set(1, SYS_MOVE_TO_SPR, 5'd3, 5'd0, 10'h009, 8'h00, 32'hDEADBEEF);
        #1;
        n_cmp++;
        if (a_ir !== 1'b1) begin n_fail++; $display("FAIL mtspr_accept: got %b want 1", a_ir); end
        @(negedge clk);
        a_set(0, SYS_NOP, 0, 0, 0, 0, 0);
        #1;
        n_cmp++;
        if ({a_gv, a_sv, a_cv} !== 3'b000) begin n_fail++; $display("FAIL mtspr_early: got %b want 000", {a_gv, a_sv, a_cv}); end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({a_gv, a_sv, a_cv} !== 3'b010) begin n_fail++; $display("FAIL mtspr_valids: got %b want 010", {a_gv, a_sv, a_cv}); end
        n_cmp++;
        if ({a_sres, a_saddr, a_sid} !== {32'hDEADBEEF, 10'h009, 5'd3}) begin
            n_fail++; $display("FAIL mtspr_payload: got %h/%h/%0d want deadbeef/009/3", a_sres, a_saddr, a_sid);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (a_sv !== 1'b0) begin n_fail++; $display("FAIL mtspr_one_cycle: got %b want 0", a_sv); end
    endtask

    task automatic test_back_to_back;
        system_op_t  ops [3];
        logic [4:0]  ids [3];
        logic [4:0]  ras [3];
        logic [7:0]  fxs [3];
        logic [31:0] dat [3];
        int emit [4];
        int idx = 0;
        exp_t e;
        int gbus; logic [4:0] gid; logic [9:0] gaddr; logic [31:0] gres; logic fire;
        ops = '{SYS_MOVE_FROM_SPR, SYS_MOVE_TO_CR, SYS_MOVE_FROM_CR};
        ids = '{5'd1, 5'd2, 5'd3};
        ras = '{5'd4, 5'd0, 5'd6};
        fxs = '{8'h00, 8'h81, 8'hFF};
        dat = '{32'h11, 32'h22, 32'h33};
        emit = '{-1, -1, -1, -1};
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (idx < 3) a_set(1, ops[idx], ids[idx], ras[idx], 10'h000, fxs[idx], dat[idx]);
            else a_set(0, SYS_NOP, 0, 0, 0, 0, 0);
            a_gr = (c >= 7); a_sr = 1'b1; a_cr = 1'b1;
            #1;
            n_cmp++;
            if (int'(a_gv) + int'(a_sv) + int'(a_cv) > 1) begin n_fail++; $display("FAIL b2b_onehot c=%0d: got %b", c, {a_gv, a_sv, a_cv}); end
            if (a_gv | a_sv | a_cv) begin
                gbus  = a_gv ? 0 : (a_sv ? 1 : 2);
                gid   = a_gv ? a_gid : (a_sv ? a_sid : a_cid);
                gaddr = a_gv ? {5'd0, a_gaddr} : (a_sv ? a_saddr : 10'd0);
                gres  = a_gv ? a_gres : (a_sv ? a_sres : a_cres);
                fire  = a_gv ? a_gr : (a_sv ? a_sr : a_cr);
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra c=%0d: got id %0d want none", c, gid);
                end else begin
                    e = sb[0];
                    if (gbus !== e.bus || gid !== e.id || gaddr !== e.addr || gres !== e.res ||
                        (gbus == 2 && pack_en(a_cen) !== e.fxm)) begin
                        n_fail++;
                        $display("FAIL b2b_out c=%0d: got bus%0d id%0d addr%h res%h en%h want bus%0d id%0d addr%h res%h en%h",
                                 c, gbus, gid, gaddr, gres, pack_en(a_cen), e.bus, e.id, e.addr, e.res, e.fxm);
                    end
                    if (fire) begin void'(sb.pop_front()); emit[e.id] = c; end
                end
            end
            if (a_iv && a_ir) begin
                sb.push_back(model(ops[idx], ids[idx], ras[idx], 10'h000, fxs[idx], dat[idx]));
                idx++;
            end
        end
        n_cmp++;
        if (sb.size() != 0 || idx != 3) begin n_fail++; $display("FAIL b2b_drain: got %0d left, %0d issued want 0, 3", sb.size(), idx); end
        n_cmp++;
        if (emit[1] != 7 || emit[2] != 8 || emit[3] != 9) begin
            n_fail++; $display("FAIL b2b_order: got cycles %0d %0d %0d want 7 8 9", emit[1], emit[2], emit[3]);
        end
        a_gr = 1'b1;
    endtask

    task automatic test_illegal;
        @(negedge clk);
        a_gr = 1'b0; a_sr = 1'b0; a_cr = 1'b0;
        a_set(1, SYS_SYNC, 5'd7, 5'd1, 10'h000, 8'h00, 32'h77);
        #1;
        n_cmp++;
        if (a_ir !== 1'b1) begin n_fail++; $display("FAIL illegal_accept: got %b want 1", a_ir); end
        @(negedge clk);
        a_set(1, SYS_MOVE_FROM_SPR, 5'd8, 5'd9, 10'h000, 8'h00, 32'h88);
        #1;
        n_cmp++;
        if (a_ir !== 1'b1) begin n_fail++; $display("FAIL illegal_accept2: got %b want 1", a_ir); end
        @(negedge clk);
        a_set(0, SYS_NOP, 0, 0, 0, 0, 0);
        #1;
        n_cmp++;
        if ({a_gv, a_sv, a_cv, a_ir} !== 4'b0001) begin
            n_fail++; $display("FAIL illegal_head: got valids/ready %b want 0001", {a_gv, a_sv, a_cv, a_ir});
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({a_gv, a_gid, a_gaddr, a_gres} !== {1'b1, 5'd8, 5'd9, 32'h88}) begin
            n_fail++; $display("FAIL illegal_next: got v%b id%0d addr%0d res%h want v1 id8 addr9 res88", a_gv, a_gid, a_gaddr, a_gres);
        end
        @(negedge clk);
        a_gr = 1'b1;
        #1;
        n_cmp++;
        if ({a_gv, a_gid} !== {1'b1, 5'd8}) begin n_fail++; $display("FAIL illegal_hold: got v%b id%0d want v1 id8", a_gv, a_gid); end
        @(negedge clk);
        a_sr = 1'b1; a_cr = 1'b1;
        #1;
        n_cmp++;
        if (a_gv !== 1'b0) begin n_fail++; $display("FAIL illegal_drain: got %b want 0", a_gv); end
    endtask

    task automatic test_mfocrf;
        logic [31:0] want1;
`ifdef SYS_MOVE_MFOCRF_EN
        want1 = 32'h02040000;
`else
        want1 = 32'h12345678;
`endif
        @(negedge clk);
        a_set(1, SYS_MOVE_FROM_CR, 5'd5, 5'd2, 10'h000, 8'h50, 32'h12345678);
        @(negedge clk);
        a_set(1, SYS_MOVE_FROM_CR, 5'd6, 5'd3, 10'h000, 8'hFF, 32'h12345678);
        @(negedge clk);
        a_set(0, SYS_NOP, 0, 0, 0, 0, 0);
        #1;
        n_cmp++;
        if ({a_gv, a_gid, a_gres} !== {1'b1, 5'd5, want1}) begin
            n_fail++; $display("FAIL mfcr_fxm50: got v%b id%0d res%h want v1 id5 res%h", a_gv, a_gid, a_gres, want1);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({a_gv, a_gid, a_gres} !== {1'b1, 5'd6, 32'h12345678}) begin
            n_fail++; $display("FAIL mfcr_fxmff: got v%b id%0d res%h want v1 id6 res12345678", a_gv, a_gid, a_gres);
        end
    endtask

    task automatic test_random;
        int issued = 0;
        int tail = 0;
        bit pending = 0;
        system_op_t op; logic [4:0] id, ra; logic [9:0] spr; logic [7:0] fx; logic [31:0] d;
        exp_t e;
        int gbus; logic [4:0] gid; logic [9:0] gaddr; logic [31:0] gres; logic fire;
        op = SYS_NOP; id = '0; ra = '0; spr = '0; fx = '0; d = '0;
        // unstalled latency at depth 4
        @(negedge clk);
        b_gr = 1'b1; b_sr = 1'b1; b_cr = 1'b1;
        b_set(1, SYS_MOVE_FROM_SPR, 5'd20, 5'd7, 10'h000, 8'h00, 32'hCAFE0001);
        #1;
        n_cmp++;
        if (b_ir !== 1'b1) begin n_fail++; $display("FAIL lat4_accept: got %b want 1", b_ir); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            b_set(0, SYS_NOP, 0, 0, 0, 0, 0);
            #1;
            n_cmp++;
            if (b_gv !== (k == 4)) begin n_fail++; $display("FAIL lat4_k%0d: got %b want %b", k, b_gv, (k == 4)); end
        end
        n_cmp++;
        if ({b_gid, b_gres} !== {5'd20, 32'hCAFE0001}) begin n_fail++; $display("FAIL lat4_payload: got %0d/%h want 20/cafe0001", b_gid, b_gres); end
        for (int c = 0; c < 800 && tail < 6; c++) begin
            @(negedge clk);
            if (!pending && issued < 20 && $urandom_range(0, 3) != 0) begin
                op = system_op_t'(3'($urandom_range(0, 7)));
                id = 5'(issued); ra = 5'($urandom); spr = 10'($urandom); fx = 8'($urandom); d = $urandom;
                pending = 1;
            end
            b_set(pending, op, id, ra, spr, fx, d);
            b_gr = ($urandom_range(0, 2) != 0);
            b_sr = ($urandom_range(0, 2) != 0);
            b_cr = ($urandom_range(0, 2) != 0);
            #1;
            n_cmp++;
            if (int'(b_gv) + int'(b_sv) + int'(b_cv) > 1) begin n_fail++; $display("FAIL rnd_onehot c=%0d: got %b", c, {b_gv, b_sv, b_cv}); end
            if (b_gv | b_sv | b_cv) begin
                gbus  = b_gv ? 0 : (b_sv ? 1 : 2);
                gid   = b_gv ? b_gid : (b_sv ? b_sid : b_cid);
                gaddr = b_gv ? {5'd0, b_gaddr} : (b_sv ? b_saddr : 10'd0);
                gres  = b_gv ? b_gres : (b_sv ? b_sres : b_cres);
                fire  = b_gv ? b_gr : (b_sv ? b_sr : b_cr);
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL rnd_extra c=%0d: got id %0d want none", c, gid);
                end else begin
                    e = sb[0];
                    if (gbus !== e.bus || gid !== e.id || gaddr !== e.addr || gres !== e.res ||
                        (gbus == 2 && pack_en(b_cen) !== e.fxm)) begin
                        n_fail++;
                        $display("FAIL rnd_out c=%0d: got bus%0d id%0d addr%h res%h en%h want bus%0d id%0d addr%h res%h en%h",
                                 c, gbus, gid, gaddr, gres, pack_en(b_cen), e.bus, e.id, e.addr, e.res, e.fxm);
                    end
                    if (fire) void'(sb.pop_front());
                end
            end
            if (b_iv && b_ir) begin
                e = model(op, id, ra, spr, fx, d);
                if (e.bus != 3) sb.push_back(e);
                pending = 0;
                issued++;
            end
            if (issued == 20 && sb.size() == 0) tail++;
        end
        n_cmp++;
        if (issued != 20 || sb.size() != 0) begin
            n_fail++; $display("FAIL rnd_complete: got %0d issued %0d pending want 20 issued 0 pending", issued, sb.size());
        end
        b_set(0, SYS_NOP, 0, 0, 0, 0, 0);
        b_gr = 1'b1; b_sr = 1'b1; b_cr = 1'b1;
    endtask

    task automatic test_reset_inflight;
        bit seen = 0;
        @(negedge clk);
        a_gr = 1'b0;
        a_set(1, SYS_MOVE_FROM_SPR, 5'd10, 5'd1, 10'h000, 8'h00, 32'hA0);
        @(negedge clk);
        a_set(1, SYS_MOVE_FROM_SPR, 5'd11, 5'd2, 10'h000, 8'h00, 32'hA1);
        @(negedge clk);
        a_set(0, SYS_NOP, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a_gr = 1'b1;
        #1;
        n_cmp++;
        if ({a_gv, a_sv, a_cv, a_ir} !== 4'b0001) begin
            n_fail++; $display("FAIL rst_flight_state: got valids/ready %b want 0001", {a_gv, a_sv, a_cv, a_ir});
        end
        n_cmp++;
        if ({a_gid, a_gres} !== 37'd0) begin n_fail++; $display("FAIL rst_flight_data: got %0d/%h want 0/0", a_gid, a_gres); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (a_gv | a_sv | a_cv) seen = 1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_flight_ghost: got %b want 0", seen); end
    endtask

    initial begin
        a_set(0, SYS_NOP, 0, 0, 0, 0, 0);
        b_set(0, SYS_NOP, 0, 0, 0, 0, 0);
        a_gr = 1'b1; a_sr = 1'b1; a_cr = 1'b1;
        b_gr = 1'b1; b_sr = 1'b1; b_cr = 1'b1;
        test_reset();
        test_mtspr();
        test_back_to_back();
        test_illegal();
        test_mfocrf();
        test_random();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
